clkdiv_multi: RTL

Parametrised multi-channel programmable clock divider / tick generator for the POV LED datapath. It derives several slow enables or clocks from the 50 MHz system clock, for example the LED column strobe and the shift-register clock. Each channel has a runtime-programmable divisor and a mode (50 % toggle or single-cycle pulse). Configuration changes are loaded through a valid/ready write port and applied glitch-free at the channel's period boundary.

---
 rtl/clkdiv_pkg.sv | 15 +
 rtl/clkdiv_multi_if.sv | 14 +
 rtl/clkdiv_multi_channel.sv | 107 ++++++++++
 rtl/clkdiv_multi.sv | 56 +++++
 4 files changed

// File: rtl/clkdiv_pkg.sv
// Shared mode constants, default sizing and config record for the clkdiv_multi divider.
package clkdiv_pkg;

    localparam logic MODE_TOGGLE = 1'b0;
    localparam logic MODE_PULSE  = 1'b1;

    localparam int CLKDIV_CNT_W       = 17;
    localparam int CLKDIV_DEFAULT_DIV = 2499;

    typedef struct packed {
        logic [CLKDIV_CNT_W-1:0] div;
        logic                    mode;
    } cfg_t;

endpackage

// File: rtl/clkdiv_multi_if.sv
// Configuration write port of clkdiv_multi: valid/ready handshake carrying channel, divisor and mode.
interface clkdiv_multi_if #(
    parameter int CH_W  = 1,
    parameter int CNT_W = 17
);
    logic             wr_valid;
    logic             wr_ready;
    logic [CH_W-1:0]  wr_ch;
    logic [CNT_W-1:0] wr_div;
    logic             wr_mode;

    modport master (output wr_valid, wr_ch, wr_div, wr_mode, input wr_ready);
    modport slave  (input wr_valid, wr_ch, wr_div, wr_mode, output wr_ready);
endinterface

// File: rtl/clkdiv_multi_channel.sv
// One divider channel: counter, active and shadow config, registered clk_out/tick.
// Optional hall-sensor resync input exists when CLKDIV_SYNC_EN is defined.
module clkdiv_channel
    import clkdiv_pkg::*;
#(
    parameter int CNT_W       = CLKDIV_CNT_W,
    parameter int DEFAULT_DIV = CLKDIV_DEFAULT_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             acc,
    input  logic [CNT_W-1:0] wr_div,
    input  logic             wr_mode,
`ifdef CLKDIV_SYNC_EN
    input  logic             sync_in,
`endif
    output logic             clk_out,
    output logic             tick,
    output logic             pending
);
    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d, div_q, div_d, sdiv_q, sdiv_d;
    logic             mode_q, mode_d, smode_q, smode_d;
    logic             pend_q, pend_d, clk_q, clk_d, tick_q, tick_d;
    logic             term, sync_hit, apply;

`ifdef CLKDIV_SYNC_EN
    assign sync_hit = en & sync_in;
`else
    assign sync_hit = 1'b0;
`endif
    assign term  = en & (cnt_q == div_q);
    // A shadow only ever exists with pend_q set, so an accept in a terminal cycle waits one period.
    assign apply = pend_q & (~en | term | sync_hit);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q   <= '0;
            div_q   <= DIV_RST;
            mode_q  <= MODE_TOGGLE;
            sdiv_q  <= DIV_RST;
            smode_q <= MODE_TOGGLE;
            pend_q  <= 1'b0;
            clk_q   <= 1'b1;
            tick_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            mode_q  <= mode_d;
            sdiv_q  <= sdiv_d;
            smode_q <= smode_d;
            pend_q  <= pend_d;
            clk_q   <= clk_d;
            tick_q  <= tick_d;
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        div_d   = div_q;
        mode_d  = mode_q;
        sdiv_d  = sdiv_q;
        smode_d = smode_q;
        pend_d  = pend_q;
        clk_d   = clk_q;
        tick_d  = 1'b0;

        if (!en) begin
            if (mode_q == MODE_PULSE) clk_d = 1'b0;
        end else if (term) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            clk_d  = (mode_q == MODE_PULSE) ? 1'b1 : ~clk_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
            if (mode_q == MODE_PULSE) clk_d = 1'b0;
        end

        if (apply) begin
            div_d  = sdiv_q;
            mode_d = smode_q;
            cnt_d  = '0;
            pend_d = 1'b0;
            if (smode_q != mode_q) clk_d = (smode_q == MODE_PULSE) ? 1'b0 : clk_q;
        end

        // Resync wins over both the terminal event and the mode-change rule.
        if (sync_hit) begin
            cnt_d  = '0;
            tick_d = 1'b0;
            clk_d  = (mode_d == MODE_TOGGLE);
        end

        if (acc) begin
            sdiv_d  = wr_div;
            smode_d = wr_mode;
            pend_d  = 1'b1;
        end
    end

    assign clk_out = clk_q;
    assign tick    = tick_q;
    assign pending = pend_q;

endmodule

// File: rtl/clkdiv_multi.sv
// Multi-channel programmable clock divider / tick generator with write decode.
// Define CLKDIV_SYNC_EN to add the sync_in resync input.
module clkdiv_multi
    import clkdiv_pkg::*;
#(
    parameter int CHANNELS    = 2,
    parameter int CNT_W       = CLKDIV_CNT_W,
    parameter int DEFAULT_DIV = CLKDIV_DEFAULT_DIV,
    parameter int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] en,
`ifdef CLKDIV_SYNC_EN
    input  logic                sync_in,
`endif
    clkdiv_multi_if.slave       wr,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick,
    output logic [CHANNELS-1:0] pending
);
    logic                ready;
    logic [CHANNELS-1:0] acc;

    // Out-of-range channels stay ready so their writes drain and are dropped.
    always_comb begin
        ready = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            if (wr.wr_ch == CH_W'(i)) ready = ~pending[i];
        end
    end
    assign wr.wr_ready = ready;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        assign acc[g] = wr.wr_valid & ready & (wr.wr_ch == CH_W'(g));

        clkdiv_channel #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .en      (en[g]),
            .acc     (acc[g]),
            .wr_div  (wr.wr_div),
            .wr_mode (wr.wr_mode),
`ifdef CLKDIV_SYNC_EN
            .sync_in (sync_in),
`endif
            .clk_out (clk_out[g]),
            .tick    (tick[g]),
            .pending (pending[g])
        );
    end

endmodule
